// File: rtl/mem_ctrl_pkg.sv
// Purpose: shared FSM encoding and default region tables for multi_region_mem_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Region tables are packed with region 0 in the least-significant slice.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        CAPTURE = 3'd2,
        RESP    = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam int WAIT_W = 4;

    // Default map: four 64 KiB windows.
    localparam logic [4*32-1:0] DEF_REG_BASE = {32'h4000_0000, 32'h2000_0000,
                                                32'h1000_0000, 32'h0000_0000};
    localparam logic [4*32-1:0] DEF_REG_MASK = {4{32'hFFFF_0000}};
    localparam logic [4*WAIT_W-1:0] DEF_REG_WAIT = {4'd2, 4'd4, 4'd1, 4'd0};
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/region_decoder.sv
// Purpose: match an address against NREG base/mask windows and extract the region offset.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows the input address.
//
// Ports:
//   i_addr   - address to decode
//   o_hit    - one bit per region whose window contains i_addr
//   o_multi  - more than one region matched (overlapping map)
//   o_offset - i_addr with the matching region's mask bits cleared
module region_decoder #(
    parameter int                     NREG     = 4,
    parameter int                     ADDR_W   = 32,
    parameter logic [NREG*ADDR_W-1:0] REG_BASE = '0,
    parameter logic [NREG*ADDR_W-1:0] REG_MASK = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NREG-1:0]   o_hit,
    output logic              o_multi,
    output logic [ADDR_W-1:0] o_offset
);

    always_comb begin
        o_hit    = '0;
        o_offset = '0;
        for (int k = 0; k < NREG; k++) begin
            if ((i_addr & REG_MASK[k*ADDR_W +: ADDR_W]) == REG_BASE[k*ADDR_W +: ADDR_W]) begin
                o_hit[k] = 1'b1;
                // On a multi-hit the offset is meaningless; the caller errors out.
                o_offset = o_offset | (i_addr & ~REG_MASK[k*ADDR_W +: ADDR_W]);
            end
        end
    end

    assign o_multi = ($countones(o_hit) > 1);

endmodule

// File: rtl/multi_region_mem_ctrl.sv
// Purpose: single-outstanding CPU-to-memory bridge routing each access to one of NREG regions.
// Latency: accept to cpu_rvalid = REG_WAIT[k] + busy cycles + 3; decode error = 1 cycle.
// Backpressure: cpu_ready only in IDLE; region busy extends ACCESS, capped at TIMEOUT cycles.
//
// Ports:
//   clk, rst                         - clock, synchronous active-low reset
//   cpu_req/we/addr/wdata/be         - request, sampled when cpu_req & cpu_ready
//   cpu_ready/rvalid/rdata/error     - accept, completion pulse, read data, error flag
//   mem_sel/strobe/we/addr/wdata/be  - region select (one-hot), commit pulse, access fields
//   mem_rdata, mem_busy              - per-region read data and busy
module multi_region_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                       DATA_W   = 32,
    parameter int                       ADDR_W   = 32,
    parameter int                       NREG     = 4,
    parameter logic [NREG*ADDR_W-1:0]   REG_BASE = DEF_REG_BASE,
    parameter logic [NREG*ADDR_W-1:0]   REG_MASK = DEF_REG_MASK,
    parameter logic [NREG*WAIT_W-1:0]   REG_WAIT = DEF_REG_WAIT,
    parameter int                       TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic [DATA_W/8-1:0]      cpu_be,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_error,

    output logic [NREG-1:0]          mem_sel,
    output logic                     mem_strobe,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W/8-1:0]      mem_be,
    input  logic [NREG*DATA_W-1:0]   mem_rdata,
    input  logic [NREG-1:0]          mem_busy
);

    localparam int BE_W   = DATA_W / 8;
    localparam int BCNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;

    logic [NREG-1:0]     r_sel;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [WAIT_W-1:0]   r_wait;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [DATA_W-1:0]   r_rdata;

    logic [NREG-1:0]     w_hit;
    logic                w_multi;
    logic [ADDR_W-1:0]   w_offset;
    logic                w_misalign;
    logic                w_dec_ok;
    logic [WAIT_W-1:0]   w_wait_ld;
    logic                w_busy;
    logic                w_wait_zero;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_ready;
    logic                w_strobe;
    logic                w_rvalid;
    logic                w_error;

    // The request fields are registered at the accept edge, and the IDLE
    // branch decision is taken at that same edge, so the decoder looks at the
    // incoming address. What it sees is exactly the value being latched.
    region_decoder #(
        .NREG     (NREG),
        .ADDR_W   (ADDR_W),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK)
    ) u_dec (
        .i_addr   (cpu_addr),
        .o_hit    (w_hit),
        .o_multi  (w_multi),
        .o_offset (w_offset)
    );

    assign w_misalign = |(cpu_addr & ADDR_W'(BE_W - 1));
    assign w_dec_ok   = (|w_hit) && !w_multi && !w_misalign;

    always_comb begin
        w_wait_ld = '0;
        for (int k = 0; k < NREG; k++) begin
            if (w_hit[k]) w_wait_ld = w_wait_ld | REG_WAIT[k*WAIT_W +: WAIT_W];
        end
    end

    always_comb begin
        w_rdata_sel = '0;
        for (int k = 0; k < NREG; k++) begin
            if (r_sel[k]) w_rdata_sel = w_rdata_sel | mem_rdata[k*DATA_W +: DATA_W];
        end
    end

    assign w_busy      = |(mem_busy & r_sel);
    assign w_wait_zero = (r_wait == '0);
    // Fires on the busy cycle that would make the count reach TIMEOUT.
    assign w_timeout   = w_busy && (r_bcnt == BCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_strobe = 1'b0;
        w_rvalid = 1'b0;
        w_error  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (cpu_req) w_next = w_dec_ok ? ACCESS : ERR;
            end
            ACCESS: begin
                if (w_wait_zero && !w_busy) begin
                    w_strobe = 1'b1;
                    w_next   = CAPTURE;
                end else if (w_wait_zero && w_timeout) begin
                    w_next = ERR;
                end
            end
            CAPTURE: w_next = RESP;
            RESP: begin
                w_rvalid = 1'b1;
                w_next   = IDLE;
            end
            ERR: begin
                w_rvalid = 1'b1;
                w_error  = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Reset aborts in flight: no commit or completion may escape during
        // the reset cycle itself.
        if (!rst) begin
            w_next   = IDLE;
            w_ready  = 1'b0;
            w_strobe = 1'b0;
            w_rvalid = 1'b0;
            w_error  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_wait  <= '0;
            r_bcnt  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_addr  <= w_offset;
                        r_wdata <= cpu_wdata;
                        r_be    <= cpu_be;
                        r_sel   <= w_dec_ok ? w_hit : '0;
                        r_wait  <= w_wait_ld;
                        r_bcnt  <= '0;
                    end
                end
                ACCESS: begin
                    if (!w_wait_zero)  r_wait <= r_wait - 1'b1;
                    else if (w_busy)   r_bcnt <= r_bcnt + 1'b1;
                end
                CAPTURE: begin
                    if (!r_we) r_rdata <= w_rdata_sel;
                end
                default: ;
            endcase
        end
    end

    assign cpu_ready  = w_ready;
    assign cpu_rvalid = w_rvalid;
    assign cpu_error  = w_error;
    assign cpu_rdata  = r_rdata;

    assign mem_sel    = ((r_state == ACCESS) || (r_state == CAPTURE)) ? r_sel : '0;
    assign mem_strobe = w_strobe;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_be     = r_be;

endmodule
